// File: rtl/updi_output_handler_if.sv
// FIFO-side signals of the UPDI output handler: host command FIFO read port,
// UART TX FIFO write port and UART RX (echo) FIFO read port.
interface updi_output_handler_if;
  logic [7:0] in_fifo_data;
  logic       in_fifo_empty;
  logic       in_fifo_rd_en;
  logic [7:0] tx_fifo_data;
  logic       tx_fifo_full;
  logic       tx_fifo_wr_en;
  logic [7:0] echo_fifo_data;
  logic       echo_fifo_empty;
  logic       echo_fifo_rd_en;

  modport master (
    input  in_fifo_data, in_fifo_empty, tx_fifo_full, echo_fifo_data, echo_fifo_empty,
    output in_fifo_rd_en, tx_fifo_data, tx_fifo_wr_en, echo_fifo_rd_en
  );

  modport slave (
    output in_fifo_data, in_fifo_empty, tx_fifo_full, echo_fifo_data, echo_fifo_empty,
    input  in_fifo_rd_en, tx_fifo_data, tx_fifo_wr_en, echo_fifo_rd_en
  );
endinterface

// File: rtl/updi_output_handler.sv
// Moves host command bytes to the UART TX FIFO one at a time, optionally
// preceded by a SYNC byte, and verifies each byte against its line echo.
module updi_output_handler #(
  parameter int unsigned BITS_N       = 6,
  parameter int unsigned TIMEOUT_CLKS = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_N-1:0] n_bytes,
  input  logic              send_sync,
  input  logic              start,
  output logic              ready,
  output logic              done,
  output logic              timeout,
  output logic              echo_error,
  updi_output_handler_if.master fifo
);

  localparam int unsigned STALL_W   = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]  SYNC_BYTE = 8'h55;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, WRITE, ECHO_WAIT, ECHO_CHK, FINISH, ABORT
  } state_e;

  state_e              state_q, state_d;
  logic [BITS_N-1:0]   rem_q, rem_d;
  logic [7:0]          hold_q, hold_d;
  logic                sync_q, sync_d;
  logic                err_q, err_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                stalled;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      hold_q  <= '0;
      sync_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
      sync_q  <= sync_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hold_d  = hold_q;
    sync_d  = sync_q;
    err_d   = err_q;
    stalled = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d  = n_bytes;
          sync_d = send_sync;
          err_d  = 1'b0;
          if (send_sync) begin
            hold_d  = SYNC_BYTE;
            state_d = WRITE;
          end else if (n_bytes == '0) begin
            state_d = FINISH;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (!fifo.in_fifo_empty) state_d = LOAD;
        else                     stalled = 1'b1;
      end
      LOAD: begin
        hold_d  = fifo.in_fifo_data;
        state_d = WRITE;
      end
      WRITE: begin
        if (!fifo.tx_fifo_full) state_d = ECHO_WAIT;
        else                    stalled = 1'b1;
      end
      ECHO_WAIT: begin
        if (!fifo.echo_fifo_empty) state_d = ECHO_CHK;
        else                       stalled = 1'b1;
      end
      ECHO_CHK: begin
        if (fifo.echo_fifo_data != hold_q) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (sync_q) begin
          // The SYNC byte is not part of the payload count.
          sync_d  = 1'b0;
          state_d = (rem_q == '0) ? FINISH : FETCH;
        end else begin
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == BITS_N'(1)) ? FINISH : FETCH;
        end
      end
      FINISH:  state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (stalled && (stall_q == STALL_W'(TIMEOUT_CLKS - 1))) state_d = ABORT;

    if (state_d != state_q) stall_d = '0;
    else if (stalled)       stall_d = stall_q + 1'b1;
    else                    stall_d = stall_q;
  end

  always_comb begin
    ready                = (state_q == IDLE);
    done                 = (state_q == FINISH);
    timeout              = (state_q == ABORT);
    echo_error           = (state_q == FINISH) && err_q;
    fifo.in_fifo_rd_en   = (state_q == FETCH)     && !fifo.in_fifo_empty;
    fifo.tx_fifo_wr_en   = (state_q == WRITE)     && !fifo.tx_fifo_full;
    fifo.echo_fifo_rd_en = (state_q == ECHO_WAIT) && !fifo.echo_fifo_empty;
    fifo.tx_fifo_data    = hold_q;
  end

endmodule

// File: tb/tb_updi_output_handler.sv
// Bench for updi_output_handler: FIFO models with TX->echo loopback and a
// transaction-level reference model of the expected byte stream and outcome.
module tb_updi_output_handler;
  localparam int unsigned BITS_N = 6;
  localparam int unsigned TO     = 25;

  logic              clk = 1'b0;
  logic              rst;
  logic [BITS_N-1:0] n_bytes;
  logic              send_sync;
  logic              start;
  logic              ready, done, timeout, echo_error;

  updi_output_handler_if fifo ();

  updi_output_handler #(.BITS_N(BITS_N), .TIMEOUT_CLKS(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .n_bytes    (n_bytes),
    .send_sync  (send_sync),
    .start      (start),
    .ready      (ready),
    .done       (done),
    .timeout    (timeout),
    .echo_error (echo_error),
    .fifo       (fifo)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatch = 0;
  int cycle      = 0;

  logic [7:0] hq[$], eq[$], txq[$], hb_plan[$], exp_tx[$];
  int full_cnt = 0, host_hold = 0, echo_hold = 0, force_echo_hold = -1;
  bit rand_stall = 0;
  int corrupt_idx = -1, tx_idx = 0;
  int host_reads, done_cnt, to_cnt, err_at_done, stray = 0;
  int start_cyc, done_cyc, to_cyc;
  int exp_reads, exp_done, exp_to, exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: observe strobes mid-cycle, then apply FIFO effects after the edge.
  task automatic tick();
    logic rd_in, wr_tx, rd_ec;
    logic [7:0] txd;
    @(negedge clk);
    cycle++;
    rd_in = fifo.in_fifo_rd_en;
    wr_tx = fifo.tx_fifo_wr_en;
    rd_ec = fifo.echo_fifo_rd_en;
    txd   = fifo.tx_fifo_data;
    if (done) begin
      done_cnt++;
      err_at_done = int'(echo_error);
      if (done_cyc < 0) done_cyc = cycle;
    end
    if (timeout) begin
      to_cnt++;
      if (to_cyc < 0) to_cyc = cycle;
    end
    if (echo_error && !done) stray++;
    if ((rd_in || wr_tx || rd_ec) && (ready || done || timeout || !rst)) stray++;
    @(posedge clk);
    #1;
    if (rd_in && hq.size() > 0) begin
      fifo.in_fifo_data = hq.pop_front();
      host_reads++;
      host_hold = rand_stall ? int'($urandom_range(0, 4)) : 0;
    end
    if (wr_tx) begin
      txq.push_back(txd);
      eq.push_back((tx_idx == corrupt_idx) ? (txd ^ 8'h80) : txd);
      tx_idx++;
      if (rand_stall) full_cnt = int'($urandom_range(0, 4));
      echo_hold = (force_echo_hold >= 0) ? force_echo_hold
                : (rand_stall ? int'($urandom_range(0, 4)) : 0);
    end
    if (rd_ec && eq.size() > 0) fifo.echo_fifo_data = eq.pop_front();
    if (full_cnt > 0)  full_cnt--;
    if (host_hold > 0) host_hold--;
    if (echo_hold > 0) echo_hold--;
    fifo.tx_fifo_full    = (full_cnt > 0);
    fifo.in_fifo_empty   = (hq.size() == 0) || (host_hold > 0);
    fifo.echo_fifo_empty = (eq.size() == 0) || (echo_hold > 0);
  endtask

  // Expected outcome: stream = optional SYNC then payload bytes; stop at the
  // first corrupted echo or when the host FIFO runs dry.
  function automatic void model(input int n, input bit sync, input int avail,
                                input int ci, input bit blocked);
    logic [7:0] b;
    exp_tx.delete();
    exp_reads = 0; exp_done = 0; exp_to = 0; exp_err = 0;
    if (blocked) begin
      exp_to = 1;
      return;
    end
    for (int i = 0; i < n + int'(sync); i++) begin
      if (sync && i == 0) begin
        b = 8'h55;
      end else begin
        if (exp_reads >= avail) begin
          exp_to = 1;
          return;
        end
        b = hb_plan[exp_reads];
        exp_reads++;
      end
      exp_tx.push_back(b);
      if (i == ci) begin
        exp_err  = 1;
        exp_done = 1;
        return;
      end
    end
    exp_done = 1;
  endfunction

  task automatic flush();
    hq.delete();
    eq.delete();
    full_cnt = 0; host_hold = 0; echo_hold = 0;
    fifo.tx_fifo_full    = 1'b0;
    fifo.in_fifo_empty   = 1'b1;
    fifo.echo_fifo_empty = 1'b1;
  endtask

  task automatic run_txn(input int n, input bit sync, input int avail,
                         input int ci, input bit blocked, input string tag);
    model(n, sync, avail, ci, blocked);
    hq.delete();
    for (int i = 0; i < avail; i++) hq.push_back(hb_plan[i]);
    if (avail == n) begin
      hq.push_back(8'($urandom));
      hq.push_back(8'($urandom));
    end
    fifo.in_fifo_empty = (hq.size() == 0) || (host_hold > 0);
    txq.delete();
    tx_idx = 0; corrupt_idx = ci;
    host_reads = 0; done_cnt = 0; to_cnt = 0; err_at_done = 0;
    done_cyc = -1; to_cyc = -1;
    n_bytes   = BITS_N'(n);
    send_sync = sync;
    start     = 1'b1;
    start_cyc = cycle + 1;
    tick();
    start     = 1'b0;
    n_bytes   = BITS_N'($urandom);
    send_sync = 1'($urandom);
    for (int k = 0; k < 4000 && done_cnt == 0 && to_cnt == 0; k++) tick();
    repeat (3) tick();
    check({tag, " done_pulses"}, done_cnt, exp_done);
    check({tag, " timeout_pulses"}, to_cnt, exp_to);
    check({tag, " echo_error"}, err_at_done, exp_err);
    check({tag, " host_reads"}, host_reads, exp_reads);
    check({tag, " tx_count"}, txq.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < txq.size(); i++)
      check({tag, " tx_byte"}, txq[i], exp_tx[i]);
    check({tag, " ready_back"}, ready, 1'b1);
    flush();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; n_bytes = '0; send_sync = 1'b0;
    fifo.in_fifo_data    = 8'hA5;
    fifo.echo_fifo_data  = 8'h5A;
    fifo.in_fifo_empty   = 1'b0;
    fifo.tx_fifo_full    = 1'b0;
    fifo.echo_fifo_empty = 1'b0;
    start = 1'b1;
    #2;
    check("reset_outputs", {ready, done, timeout, echo_error, fifo.in_fifo_rd_en,
                            fifo.tx_fifo_wr_en, fifo.echo_fifo_rd_en}, 7'b1000000);
    check("reset_tx_data", fifo.tx_fifo_data, 8'h00);
    tick(); tick();
    start = 1'b0;
    flush();
    rst = 1'b1;
    tick(); tick();

    hb_plan = '{8'hC2, 8'h08};
    run_txn(2, 1'b1, 2, -1, 1'b0, "sync_two_bytes");

    run_txn(0, 1'b0, 0, -1, 1'b0, "zero_bytes");
    check("zero_bytes done_latency", done_cyc - start_cyc, 1);

    hb_plan = '{8'h3C};
    run_txn(1, 1'b0, 0, -1, 1'b0, "host_empty");
    check("host_empty timeout_latency", to_cyc - start_cyc, TO + 1);

    hb_plan = '{8'hC2, 8'h08, 8'h33};
    run_txn(3, 1'b1, 3, 2, 1'b0, "echo_corrupt");

    hb_plan = '{8'h9E};
    full_cnt = 10; fifo.tx_fifo_full = 1'b1;
    run_txn(1, 1'b1, 1, -1, 1'b0, "tx_full_10");
    full_cnt = TO + 1; fifo.tx_fifo_full = 1'b1;
    run_txn(1, 1'b1, 1, -1, 1'b1, "tx_full_25");

    // Reset in the middle of waiting for an echo.
    force_echo_hold = 20;
    hq.delete(); hq.push_back(8'h77);
    fifo.in_fifo_empty = 1'b0;
    txq.delete(); tx_idx = 0; corrupt_idx = -1;
    n_bytes = BITS_N'(1); send_sync = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50 && txq.size() == 0; k++) tick();
    tick();
    rst = 1'b0;
    #1;
    check("midreset_outputs", {ready, done, timeout, echo_error, fifo.in_fifo_rd_en,
                               fifo.tx_fifo_wr_en, fifo.echo_fifo_rd_en}, 7'b1000000);
    check("midreset_tx_data", fifo.tx_fifo_data, 8'h00);
    repeat (3) tick();
    check("midreset tx_count", txq.size(), 1);
    force_echo_hold = -1;
    flush();
    rst = 1'b1;
    tick();
    hb_plan = '{8'h11, 8'hE4};
    run_txn(2, 1'b0, 2, -1, 1'b0, "after_reset");

    rand_stall = 1'b1;
    hb_plan.delete();
    for (int i = 0; i < 63; i++) hb_plan.push_back(8'($urandom));
    run_txn(63, 1'b1, 63, -1, 1'b0, "max_count");

    for (int t = 0; t < 40; t++) begin
      int n, avail, ci;
      bit sync;
      n     = int'($urandom_range(0, 6));
      sync  = 1'($urandom);
      avail = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : n;
      ci    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n + int'(sync))) : -1;
      hb_plan.delete();
      for (int i = 0; i < n; i++) hb_plan.push_back(8'($urandom));
      run_txn(n, sync, avail, ci, 1'b0, "random");
    end

    check("stray_strobes_or_error", stray, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end
endmodule

// File: doc/updi_output_handler.md
UPDI_OUTPUT_HANDLER -- requirements
Module: updi_output_handler

Interface
REQ-001 SHALL have parameter BITS_N, default 6, width of byte-count input.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 25, consecutive stalled clocks before abort.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port n_bytes  input  BITS_N  payload byte count, sampled at start.
REQ-006 SHALL have port send_sync  input  1  prepend SYNC byte 0x55, sampled at start.
REQ-007 SHALL have ports start (in, 1), ready (out, 1), done (out, 1), timeout (out, 1), echo_error (out, 1): control and status.
REQ-008 SHALL have ports in_fifo_data (in, 8), in_fifo_empty (in, 1), in_fifo_rd_en (out, 1): host command FIFO read side.
REQ-009 SHALL have ports tx_fifo_data (out, 8), tx_fifo_full (in, 1), tx_fifo_wr_en (out, 1): UART TX FIFO write side.
REQ-010 SHALL have ports echo_fifo_data (in, 8), echo_fifo_empty (in, 1), echo_fifo_rd_en (out, 1): UART RX FIFO read side; the single-wire line echoes every transmitted byte.

Function
REQ-011 SHALL treat FIFO read data as valid on the cycle after the cycle in which rd_en was high (registered FIFO output).
REQ-012 SHALL implement states IDLE, FETCH, LOAD, WRITE, ECHO_WAIT, ECHO_CHK, FINISH, ABORT.
REQ-013 SHALL assert ready only in IDLE; start while ready latches n_bytes and send_sync and leaves IDLE next cycle; start while not ready is ignored.
REQ-014 SHALL, if send_sync latched, load 0x55 into the holding register and go to WRITE without reading in_fifo; otherwise go to FETCH, or to FINISH when n_bytes is 0.
REQ-015 SHALL in FETCH assert in_fifo_rd_en for exactly one cycle when !in_fifo_empty, then go to LOAD; LOAD latches in_fifo_data into the holding register.
REQ-016 SHALL in WRITE drive tx_fifo_data from the holding register and assert tx_fifo_wr_en for exactly one cycle when !tx_fifo_full, then go to ECHO_WAIT.
REQ-017 SHALL in ECHO_WAIT assert echo_fifo_rd_en for exactly one cycle when !echo_fifo_empty, then go to ECHO_CHK.
REQ-018 SHALL in ECHO_CHK compare echo_fifo_data with the holding register; on mismatch set echo_error and go to FINISH; on match decrement remaining count (SYNC byte not counted) and go to FETCH, or FINISH when remaining is 0.
REQ-019 SHALL pulse done for exactly one cycle in FINISH, with echo_error valid in that same cycle only, then return to IDLE.
REQ-020 SHALL keep a stall counter cleared on every state transition and incremented each cycle spent in FETCH, WRITE or ECHO_WAIT without progress.
REQ-021 SHALL, when the stall counter reaches TIMEOUT_CLKS, enter ABORT, pulse timeout for exactly one cycle (done stays low), then return to IDLE.
REQ-022 SHALL NOT drain unread host bytes or unread echoes after a mismatch or timeout; flushing is the caller's job.
REQ-023 SHALL never assert more than one rd_en/wr_en strobe per state visit, and none in IDLE, FINISH or ABORT.
REQ-024 SHALL handle n_bytes at maximum (2^BITS_N-1) without counter wrap.

Reset
REQ-025 SHALL, while rst is low, force state IDLE, stall counter, remaining count and holding register to 0, and ready=1, done=0, timeout=0, echo_error=0, all rd_en/wr_en=0, tx_fifo_data=0.
REQ-026 SHALL abandon any in-progress transfer on reset assertion, with no further strobes after rst falls.

Verification
REQ-027 Host FIFO {0x55 skipped; 0xC2,0x08}, send_sync=1, n_bytes=2, loopback TX->echo -> TX sees 0x55,0xC2,0x08; done pulses once; echo_error=0; ready returns.
REQ-028 n_bytes=0, send_sync=0, start -> done pulses on the cycle after start; no strobes issued.
REQ-029 n_bytes=1, in_fifo empty throughout -> timeout pulses exactly TIMEOUT_CLKS cycles after entering FETCH; done stays 0.
REQ-030 Loopback corrupts second echo (0x08 -> 0x88) -> done and echo_error pulse together after second ECHO_CHK; third host byte not read.
REQ-031 tx_fifo_full held 10 cycles then released -> byte written once after release, no timeout; held 25 cycles -> timeout.
REQ-032 rst low during ECHO_WAIT -> outputs at reset values immediately, ready=1; new start after release completes normally.
